// File: rtl/divider_iterative.sv
// Iterative radix-2 restoring divider with RISC-V M semantics (DIV/DIVU/REM/REMU).
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration loop.
module divider_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    input  logic [1:0]       div_type,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] div_r,
    output logic [1:0]       dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // a response transfers on a rising edge where resp_valid & resp_ready. Neither
    // side may retract valid before its transfer, and flush overrides both.

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO      = '0;
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             is_rem_q, is_rem_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes; the most-negative value maps onto its own bit pattern,
    // which is the correct unsigned magnitude.
    always_comb begin
        op_signed = ~div_type[0];
        a_neg     = op_signed & div_a[WIDTH-1];
        b_neg     = op_signed & div_b[WIDTH-1];
        a_mag     = a_neg ? (ZERO - div_a) : div_a;
        b_mag     = b_neg ? (ZERO - div_b) : div_b;
    end

    // One restoring step: the dividend bits shift out of quo_q into the partial
    // remainder while quotient bits shift in at the bottom.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_shift - {1'b0, b_q};
        q_step    = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        r_step    = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        q_fix     = neg_q_q ? (ZERO - q_step) : q_step;
        r_fix     = neg_r_q ? (ZERO - r_step) : r_step;
    end

    assign accept = req_valid & (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        b_d      = b_q;
        is_rem_d = is_rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_rem_d = div_type[1];
                    neg_q_d  = a_neg ^ b_neg;
                    neg_r_d  = a_neg;
                    b_d      = b_mag;
                    quo_d    = a_mag;
                    rem_d    = ZERO;
                    cnt_d    = '0;
                    if (div_b == ZERO) begin
                        result_d = div_type[1] ? div_a : ALL_ONES;
                        state_d  = DONE;
                    end else if (op_signed && (div_a == MOST_NEG) && (div_b == ALL_ONES)) begin
                        result_d = div_type[1] ? ZERO : div_a;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = r_step;
                quo_d = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    result_d = is_rem_q ? r_fix : q_fix;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over both handshakes and drops any pending result.
        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = ZERO;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            b_q      <= '0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            b_q      <= b_d;
            is_rem_q <= is_rem_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign div_r      = result_q;
    assign dbg_state  = state_q;

endmodule
